// File: rtl/snn_run_ctrl.sv
// Run sequencer for the single-neuron STDP network: loads initial weights, plays
// NUM_STEPS spike vectors (each followed by ENCODE_TIME padding cycles) and reports the spike count.
module snn_run_ctrl #(
    parameter int N_PRE       = 2,
    parameter int W_DW        = 16,
    parameter int NUM_STEPS   = 100,
    parameter int ENCODE_TIME = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic [W_DW-1:0]   w_tdata,
    input  logic              w_tvalid,
    output logic              w_tready,
    input  logic [N_PRE-1:0]  s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [W_DW-1:0]   syn_weight,
    output logic [N_PRE-1:0]  syn_wr_en,
    output logic [N_PRE-1:0]  pre_spikes,
    output logic              net_en,
    input  logic              post_spike,
    output logic [CNT_W-1:0]  r_tdata,
    output logic              r_tvalid,
    input  logic              r_tready,
    output logic [2:0]        dbg_state
);

    // Streams: a beat transfers on a cycle where valid and ready are both high; valid
    // must not depend on ready, and a transfer in cycle t takes effect in cycle t+1.

    localparam int WI_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;
    localparam int ST_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int GP_W = (ENCODE_TIME > 1) ? $clog2(ENCODE_TIME) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_FETCH, S_APPLY, S_PAD, S_DRAIN, S_REPORT
    } state_t;

    state_t            state, state_n;
    logic [WI_W-1:0]   windex, windex_n;
    logic [ST_W-1:0]   step, step_n;
    logic [GP_W-1:0]   gap, gap_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              cnt_en;
    logic              step_end;
    logic [W_DW-1:0]   syn_weight_n;
    logic [N_PRE-1:0]  syn_wr_en_n, pre_spikes_n;
    logic              net_en_n, r_tvalid_n;
    logic [CNT_W-1:0]  r_tdata_n;

    assign busy      = (state != S_IDLE);
    assign w_tready  = (state == S_LOAD_W);
    assign s_tready  = (state == S_FETCH);
    assign dbg_state = state;

    always_comb begin
        state_n      = state;
        windex_n     = windex;
        step_n       = step;
        gap_n        = gap;
        syn_weight_n = syn_weight;
        syn_wr_en_n  = '0;
        pre_spikes_n = pre_spikes;
        net_en_n     = net_en;
        r_tdata_n    = r_tdata;
        r_tvalid_n   = r_tvalid;
        step_end     = 1'b0;
        // The neuron answers one cycle after net_en, so counting follows net_en delayed.
        cnt_n        = (cnt_en && post_spike && !(&cnt)) ? cnt + CNT_W'(1) : cnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_LOAD_W;
                    windex_n = '0;
                    cnt_n    = '0;
                end
            end
            S_LOAD_W: begin
                if (w_tvalid) begin
                    syn_weight_n = w_tdata;
                    syn_wr_en_n  = N_PRE'(1) << windex;
                    windex_n     = windex + WI_W'(1);
                    if (int'(windex) == N_PRE - 1) begin
                        state_n = S_FETCH;
                        step_n  = '0;
                    end
                end
            end
            S_FETCH: begin
                pre_spikes_n = '0;
                net_en_n     = 1'b0;
                if (s_tvalid) begin
                    pre_spikes_n = s_tdata;
                    net_en_n     = 1'b1;
                    state_n      = S_APPLY;
                end
            end
            S_APPLY: begin
                if (ENCODE_TIME > 0) begin
                    state_n      = S_PAD;
                    gap_n        = '0;
                    pre_spikes_n = '0;
                end else begin
                    step_end = 1'b1;
                end
            end
            S_PAD: begin
                pre_spikes_n = '0;
                if (int'(gap) == ENCODE_TIME - 1) step_end = 1'b1;
                else                              gap_n = gap + GP_W'(1);
            end
            S_DRAIN: begin
                net_en_n   = 1'b0;
                r_tvalid_n = 1'b1;
                r_tdata_n  = cnt_n;
                state_n    = S_REPORT;
            end
            S_REPORT: begin
                if (r_tready) begin
                    r_tvalid_n = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (step_end) begin
            net_en_n     = 1'b0;
            pre_spikes_n = '0;
            if (int'(step) == NUM_STEPS - 1) begin
                state_n = S_DRAIN;
            end else begin
                step_n  = step + ST_W'(1);
                state_n = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            windex     <= '0;
            step       <= '0;
            gap        <= '0;
            cnt        <= '0;
            cnt_en     <= 1'b0;
            syn_weight <= '0;
            syn_wr_en  <= '0;
            pre_spikes <= '0;
            net_en     <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else begin
            state      <= state_n;
            windex     <= windex_n;
            step       <= step_n;
            gap        <= gap_n;
            cnt        <= cnt_n;
            cnt_en     <= net_en;
            syn_weight <= syn_weight_n;
            syn_wr_en  <= syn_wr_en_n;
            pre_spikes <= pre_spikes_n;
            net_en     <= net_en_n;
            r_tdata    <= r_tdata_n;
            r_tvalid   <= r_tvalid_n;
        end
    end

endmodule
